// File: rtl/can_error_frame_gen.sv
// CAN error frame generator: drives the active/passive error flag, waits out
// flag superposition, then sends the error delimiter and intermission. Form
// errors in the delimiter and long dominant runs are reported on extra_error
// so the error counter can apply the fault-confinement penalties.
module can_error_frame_gen #(
  parameter int FLAG_BITS         = 6,
  parameter int DELIM_BITS        = 8,
  parameter int INTERMISSION_BITS = 3,
  parameter int MAX_DOMINANT      = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic bit_tick,
  input  logic rx_bit,
  input  logic error_detected,
  input  logic error_passive,
  input  logic bus_off,
  output logic tx_bit,
  output logic busy,
  output logic flag_active,
  output logic frame_done,
  output logic extra_error
);

  localparam logic [3:0] FLAG_LAST  = 4'(FLAG_BITS - 1);
  localparam logic [3:0] DELIM_LAST = 4'(DELIM_BITS - 1);
  localparam logic [3:0] INTER_END  = 4'(INTERMISSION_BITS);
  localparam logic [3:0] DOM_LIMIT  = 4'(MAX_DOMINANT);

  typedef enum logic [2:0] {
    IDLE,
    FLAG,
    WAIT_REC,
    DELIM,
    INTER
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [3:0] dom_cnt, dom_cnt_next;
  logic       pending, pending_next;
  logic       flag_level, flag_level_next;
  logic       tx_next, busy_next, flag_active_next;
  logic       done_next, extra_next;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    dom_cnt_next    = dom_cnt;
    pending_next    = pending;
    flag_level_next = flag_level;
    tx_next         = tx_bit;
    done_next       = 1'b0;
    extra_next      = 1'b0;

    if (!enable || bus_off) begin
      state_next      = IDLE;
      cnt_next        = 4'd0;
      dom_cnt_next    = 4'd0;
      pending_next    = 1'b0;
      flag_level_next = 1'b0;
      tx_next         = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_next = 1'b1;
          if (bit_tick && (pending || error_detected)) begin
            state_next      = FLAG;
            pending_next    = 1'b0;
            flag_level_next = error_passive;
            tx_next         = error_passive;
            cnt_next        = 4'd0;
          end else if (error_detected) begin
            pending_next = 1'b1;
          end
        end

        FLAG: begin
          tx_next = flag_level;
          if (bit_tick) begin
            if (cnt == FLAG_LAST) begin
              state_next   = WAIT_REC;
              tx_next      = 1'b1;
              dom_cnt_next = 4'd0;
            end else begin
              cnt_next = cnt + 4'd1;
            end
          end
        end

        WAIT_REC: begin
          tx_next = 1'b1;
          if (bit_tick) begin
            if (rx_bit) begin
              // The first recessive bit is already delimiter bit 1.
              if (DELIM_LAST == 4'd0) begin
                state_next = INTER;
                cnt_next   = 4'd0;
              end else begin
                state_next = DELIM;
                cnt_next   = 4'd1;
              end
            end else if (dom_cnt + 4'd1 == DOM_LIMIT) begin
              extra_next   = 1'b1;
              dom_cnt_next = 4'd0;
            end else begin
              dom_cnt_next = dom_cnt + 4'd1;
            end
          end
        end

        DELIM: begin
          tx_next = 1'b1;
          if (bit_tick) begin
            if (rx_bit) begin
              if (cnt == DELIM_LAST) begin
                state_next = INTER;
                cnt_next   = 4'd0;
              end else begin
                cnt_next = cnt + 4'd1;
              end
            end else begin
              // Dominant bit inside the delimiter is a form error: new flag.
              extra_next      = 1'b1;
              state_next      = FLAG;
              cnt_next        = 4'd0;
              flag_level_next = error_passive;
              tx_next         = error_passive;
            end
          end
        end

        INTER: begin
          tx_next = 1'b1;
          if (bit_tick) begin
            if (!rx_bit || (cnt + 4'd1 == INTER_END)) begin
              state_next = IDLE;
              cnt_next   = 4'd0;
              done_next  = 1'b1;
            end else begin
              cnt_next = cnt + 4'd1;
            end
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
          tx_next    = 1'b1;
        end
      endcase
    end

    busy_next        = (state_next != IDLE);
    flag_active_next = (state_next == FLAG);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      dom_cnt     <= 4'd0;
      pending     <= 1'b0;
      flag_level  <= 1'b0;
      tx_bit      <= 1'b1;
      busy        <= 1'b0;
      flag_active <= 1'b0;
      frame_done  <= 1'b0;
      extra_error <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      dom_cnt     <= dom_cnt_next;
      pending     <= pending_next;
      flag_level  <= flag_level_next;
      tx_bit      <= tx_next;
      busy        <= busy_next;
      flag_active <= flag_active_next;
      frame_done  <= done_next;
      extra_error <= extra_next;
    end
  end

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Testbench for can_error_frame_gen: a bus-level model judged by recessive
// run lengths is compared every clock, plus literal frame-timing checks.
module tb_can_error_frame_gen;

  localparam int FLAG_BITS  = 6;
  localparam int DELIM_BITS = 8;
  localparam int INTER_BITS = 3;
  localparam int MAX_DOM    = 8;

  logic clock          = 1'b0;
  logic reset_n        = 1'b0;
  logic enable         = 1'b1;
  logic bit_tick       = 1'b0;
  logic rx_bit         = 1'b1;
  logic error_detected = 1'b0;
  logic error_passive  = 1'b0;
  logic bus_off        = 1'b0;
  logic tx_bit, busy, flag_active, frame_done, extra_error;

  int checks = 0;
  int errors = 0;
  logic compare_on = 1'b0;

  int tick_no, dom_ticks, flag_ticks, done_cnt, done_at, extra_cnt;

  // Free-running clock.
  always #5 clock = ~clock;

  can_error_frame_gen #(
    .FLAG_BITS(FLAG_BITS),
    .DELIM_BITS(DELIM_BITS),
    .INTERMISSION_BITS(INTER_BITS),
    .MAX_DOMINANT(MAX_DOM)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .bit_tick(bit_tick),
    .rx_bit(rx_bit),
    .error_detected(error_detected),
    .error_passive(error_passive),
    .bus_off(bus_off),
    .tx_bit(tx_bit),
    .busy(busy),
    .flag_active(flag_active),
    .frame_done(frame_done),
    .extra_error(extra_error)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a frame is a flag of FLAG_BITS bits followed by a
  // run of recessive bits; it ends when that run reaches DELIM+INTER bits,
  // or on a dominant bit once the delimiter is complete.
  logic m_busy = 1'b0, m_level = 1'b0, m_pending = 1'b0;
  int   m_flag_left = 0, m_rec_run = 0, m_dom_run = 0;
  logic exp_tx = 1'b1, exp_busy = 1'b0, exp_flag = 1'b0, exp_done = 1'b0, exp_extra = 1'b0;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      exp_done  = 1'b0;
      exp_extra = 1'b0;
      if (!reset_n || !enable || bus_off) begin
        m_busy = 1'b0; m_level = 1'b0; m_pending = 1'b0;
        m_flag_left = 0; m_rec_run = 0; m_dom_run = 0;
      end else if (!m_busy) begin
        if (bit_tick && (m_pending || error_detected)) begin
          m_busy = 1'b1; m_level = error_passive; m_pending = 1'b0;
          m_flag_left = FLAG_BITS; m_rec_run = 0; m_dom_run = 0;
        end else if (error_detected) begin
          m_pending = 1'b1;
        end
      end else if (bit_tick) begin
        if (m_flag_left > 0) begin
          m_flag_left--;
        end else if (rx_bit) begin
          m_rec_run++;
          if (m_rec_run == DELIM_BITS + INTER_BITS) begin
            m_busy = 1'b0; exp_done = 1'b1;
          end
        end else if (m_rec_run == 0) begin
          m_dom_run++;
          if (m_dom_run == MAX_DOM) begin
            exp_extra = 1'b1; m_dom_run = 0;
          end
        end else if (m_rec_run < DELIM_BITS) begin
          exp_extra = 1'b1; m_level = error_passive;
          m_flag_left = FLAG_BITS; m_rec_run = 0; m_dom_run = 0;
        end else begin
          m_busy = 1'b0; exp_done = 1'b1;
        end
      end
      exp_busy = m_busy;
      exp_flag = m_busy && (m_flag_left > 0);
      exp_tx   = exp_flag ? m_level : 1'b1;
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clock) begin
    if (compare_on) begin
      checkOutput("tx_bit", tx_bit, exp_tx);
      checkOutput("busy", busy, exp_busy);
      checkOutput("flag_active", flag_active, exp_flag);
      checkOutput("frame_done", frame_done, exp_done);
      checkOutput("extra_error", extra_error, exp_extra);
    end
  end

  task automatic stepClock();
    @(negedge clock);
    if (frame_done) begin
      done_cnt++;
      done_at = tick_no;
    end
    if (extra_error) extra_cnt++;
  endtask

  task automatic startScenario();
    tick_no = -1; dom_ticks = 0; flag_ticks = 0;
    done_cnt = 0; done_at = -1; extra_cnt = 0;
  endtask

  // One bit period: tick with the bus as wired-AND of our drive and others.
  task automatic applyStimulus(input logic other_rec, input logic err);
    tick_no++;
    if (!tx_bit) dom_ticks++;
    if (flag_active) flag_ticks++;
    bit_tick = 1'b1;
    rx_bit = tx_bit & other_rec;
    error_detected = err;
    stepClock();
    bit_tick = 1'b0;
    error_detected = 1'b0;
    rx_bit = 1'b1;
    stepClock();
    stepClock();
    stepClock();
  endtask

  task automatic runTicks(input int n, input int dom_from, input int dom_to);
    for (int i = 0; i < n; i++) begin
      int nxt;
      nxt = tick_no + 1;
      applyStimulus(!(nxt >= dom_from && nxt <= dom_to), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    startScenario();
    stepClock();
    stepClock();
    checkOutput("reset tx_bit", tx_bit, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset flag_active", flag_active, 0);
    checkOutput("reset frame_done", frame_done, 0);
    reset_n = 1'b1;
    stepClock();
    compare_on = 1'b1;

    // Active flag, error coincident with the tick.
    startScenario();
    error_passive = 1'b0;
    applyStimulus(1'b1, 1'b1);
    runTicks(20, 0, -1);
    checkOutput("active dom ticks", dom_ticks, 6);
    checkOutput("active flag ticks", flag_ticks, 6);
    checkOutput("active done tick", done_at, 17);
    checkOutput("active done count", done_cnt, 1);
    checkOutput("active extra count", extra_cnt, 0);

    // Passive flag from a pending error; later error_passive change ignored.
    startScenario();
    error_passive = 1'b1;
    error_detected = 1'b1;
    stepClock();
    error_detected = 1'b0;
    stepClock();
    applyStimulus(1'b1, 1'b0);
    error_passive = 1'b0;
    runTicks(20, 0, -1);
    checkOutput("passive dom ticks", dom_ticks, 0);
    checkOutput("passive flag ticks", flag_ticks, 6);
    checkOutput("passive done tick", done_at, 17);

    // Superposition of 3 dominant bits; error during flag is ignored.
    startScenario();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    runTicks(22, 7, 9);
    checkOutput("superpos3 done tick", done_at, 20);
    checkOutput("superpos3 done count", done_cnt, 1);
    checkOutput("superpos3 extra count", extra_cnt, 0);

    // 16 dominant bits after the flag.
    startScenario();
    applyStimulus(1'b1, 1'b1);
    runTicks(36, 7, 22);
    checkOutput("superpos16 extra count", extra_cnt, 2);
    checkOutput("superpos16 done tick", done_at, 33);

    // Form error on the 4th delimiter bit.
    startScenario();
    applyStimulus(1'b1, 1'b1);
    runTicks(30, 10, 10);
    checkOutput("form extra count", extra_cnt, 1);
    checkOutput("form done count", done_cnt, 1);
    checkOutput("form done tick", done_at, 27);
    checkOutput("form dom ticks", dom_ticks, 12);

    // bus_off mid-flag, then an error while bus-off.
    startScenario();
    applyStimulus(1'b1, 1'b1);
    runTicks(3, 0, -1);
    bus_off = 1'b1;
    stepClock();
    checkOutput("busoff tx_bit", tx_bit, 1);
    checkOutput("busoff busy", busy, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("busoff no start", busy, 0);
    bus_off = 1'b0;
    runTicks(20, 0, -1);
    checkOutput("busoff dom ticks", dom_ticks, 3);
    checkOutput("busoff done count", done_cnt, 0);

    // enable dropped inside the delimiter.
    startScenario();
    applyStimulus(1'b1, 1'b1);
    runTicks(9, 0, -1);
    checkOutput("delim busy before", busy, 1);
    enable = 1'b0;
    stepClock();
    checkOutput("disable tx_bit", tx_bit, 1);
    checkOutput("disable busy", busy, 0);
    enable = 1'b1;
    runTicks(20, 0, -1);
    checkOutput("disable done count", done_cnt, 0);

    // Async reset in WAIT_REC, then a pending error discarded by reset.
    startScenario();
    applyStimulus(1'b1, 1'b1);
    runTicks(8, 7, 8);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("areset tx_bit", tx_bit, 1);
    checkOutput("areset busy", busy, 0);
    checkOutput("areset flag_active", flag_active, 0);
    stepClock();
    reset_n = 1'b1;
    stepClock();
    error_detected = 1'b1;
    stepClock();
    error_detected = 1'b0;
    #2 reset_n = 1'b0;
    stepClock();
    reset_n = 1'b1;
    stepClock();
    startScenario();
    runTicks(20, 0, -1);
    checkOutput("pending discarded dom", dom_ticks, 0);
    checkOutput("pending discarded done", done_cnt, 0);

    // bit_tick held high: every clock is one bit.
    startScenario();
    error_passive = 1'b0;
    bit_tick = 1'b1;
    error_detected = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick_no++;
      if (!tx_bit) dom_ticks++;
      rx_bit = tx_bit;
      stepClock();
      error_detected = 1'b0;
    end
    bit_tick = 1'b0;
    rx_bit = 1'b1;
    stepClock();
    checkOutput("fast dom ticks", dom_ticks, 6);
    checkOutput("fast done tick", done_at, 17);
    checkOutput("fast done count", done_cnt, 1);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_error_frame_gen.md
# can_error_frame_gen

Generates the CAN error frame after a protocol error has been flagged. It sits directly downstream of the error counter and bit-level error detectors, and directly upstream of the bus transmit mux. On a detected error it drives an active (dominant) or passive (recessive) error flag, then handles flag superposition, the 8-bit error delimiter and intermission. It also reports the extra errors that the CAN fault-confinement rules feed back into the error counter.

## Interface
- FLAG_BITS, 6, error flag length in bits.
- DELIM_BITS, 8, recessive bits in the error delimiter, including the first recessive bit seen after the flag.
- INTERMISSION_BITS, 3, recessive bits after the delimiter.
- MAX_DOMINANT, 8, consecutive dominant bits after the flag that raise extra_error.
- All parameters are in the range 1..15. Internal bit counters are 4 bits wide.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, synchronously returns the block to reset state.
- bit_tick  in  1  one-clock strobe at each bit sample point.
- rx_bit  in  1  sampled bus level, valid on bit_tick (0 = dominant).
- error_detected  in  1  error pulse from the detectors.
- error_passive  in  1  node confinement state from the error counter.
- bus_off  in  1  node is bus-off.
- tx_bit  out  1  bus drive level (0 = dominant).
- busy  out  1  state is not IDLE.
- flag_active  out  1  state is FLAG.
- frame_done  out  1  one-clock pulse at the end of an error frame.
- extra_error  out  1  one-clock pulse feeding error_detected of the error counter.

## Operation
- Reset values: state IDLE, tx_bit 1, busy 0, flag_active 0, frame_done 0, extra_error 0, pending 0, counters 0.
- Any of reset_n low, enable low, or bus_off high forces the reset state.
  - reset_n acts asynchronously; enable and bus_off act synchronously.
  - This applies mid-frame. No frame_done is issued.
- IDLE:
  - error_detected (with bus_off low) sets pending.
  - On a bit_tick where pending or error_detected is set, enter FLAG and clear pending.
  - On entry, latch flag_level = error_passive, drive tx_bit = flag_level, set cnt = 0.
- FLAG:
  - On each bit_tick: if cnt == FLAG_BITS-1, go to WAIT_REC with tx_bit 1 and dom_cnt 0; otherwise cnt++.
  - This gives exactly FLAG_BITS flag bits.
  - error_passive changes during FLAG are ignored.
- WAIT_REC (superposition): tx_bit 1. On each bit_tick:
  - rx_bit 1: go to DELIM with cnt = 1.
  - rx_bit 0: dom_cnt++. When dom_cnt reaches MAX_DOMINANT, pulse extra_error, reset dom_cnt to 0 and stay in WAIT_REC.
- DELIM: tx_bit 1. On each bit_tick:
  - rx_bit 1: if cnt == DELIM_BITS-1, go to INTER with cnt 0; otherwise cnt++.
  - rx_bit 0 (form error): pulse extra_error and re-enter FLAG, relatching flag_level from the current error_passive.
- INTER: tx_bit 1. On each bit_tick:
  - cnt++. When cnt reaches INTERMISSION_BITS, go to IDLE with a frame_done pulse.
  - rx_bit 0 during INTER (start of frame from another node) also ends the frame: go to IDLE with frame_done.
- error_detected while busy is ignored and does not set pending, except for the DELIM form-error path.
- extra_error and frame_done never assert in the same cycle.

## Timing
- All outputs are registered.
- State and tx_bit change in the clock cycle after the bit_tick that causes the transition.
- error_detected to first flag bit on tx_bit: next bit_tick plus 1 clock.
  - error_detected coincident with bit_tick counts as pending for that tick.
- Flag duration: FLAG_BITS bit periods.
- Minimum frame with no superposition: FLAG_BITS + DELIM_BITS + INTERMISSION_BITS bit periods (default 17). The first recessive bit observed in WAIT_REC counts as delimiter bit 1.
- frame_done and extra_error are high for exactly 1 clock, aligned to the registered transition.
- With bit_tick held high every clock, the block must still sequence correctly; each clock is one bit.

## Test plan
- Active flag:
  - Stimulus: error_passive 0, error_detected pulse, rx_bit follows tx_bit and reads 1 after the flag.
  - Response: tx_bit 0 for 6 ticks, then 1 for 11 ticks; frame_done one clock after tick 17; extra_error never asserts.
- Passive flag:
  - Stimulus: error_passive 1 with the same sequence.
  - Response: tx_bit stays 1 throughout, flag_active for 6 ticks, frame_done after 17 ticks.
- Superposition:
  - Stimulus: rx_bit held 0 for 3 ticks after the flag.
  - Response: DELIM entered on tick 10; frame_done after 20 ticks, no extra_error.
  - Stimulus: rx_bit held 0 for 16 ticks after the flag.
  - Response: exactly 2 extra_error pulses.
- Form error:
  - Stimulus: rx_bit 0 on the 4th delimiter tick.
  - Response: extra_error pulse, new 6-bit flag, then a complete frame and a single frame_done.
- Abort:
  - Stimulus: bus_off asserted mid-flag, and separately enable dropped in DELIM.
  - Response: next clock tx_bit 1, busy 0, no frame_done. error_detected while bus_off is high never starts a frame.
- Async reset:
  - Stimulus: reset_n low mid-WAIT_REC.
  - Response: all outputs at reset values immediately; a pending error latched before the reset is discarded.
